cordic_sine_gen: RTL and testbench

CORDIC_SINE_GEN -- requirements
Module: cordic_sine_gen

---
 rtl/cordic_pkg.sv | 51 +++++
 rtl/cordic_rotator.sv | 49 ++++
 rtl/cordic_sine_gen.sv | 161 ++++++++++++++++
 tb/tb_cordic_sine_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC sine-table generator: FSM states,
// Q1.14 fixed-point widths, the CORDIC gain constant and the arctan ROM.
package cordic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROTATE,
    S_SCALE,
    S_WRITE
  } state_t;

  localparam int unsigned Q14_W       = 16;
  localparam int unsigned FRAC_W      = 14;
  localparam int unsigned DP_W        = 18;
  localparam int unsigned PROD_W      = 26;
  localparam int unsigned ITER_IDX_W  = 5;
  localparam int unsigned ROW_W       = 10;
  localparam int unsigned PHASE_W     = 16;
  localparam int unsigned ONE_Q14     = 16384;
  localparam int unsigned SCROLL_STEP = 256;

  localparam logic [Q14_W-1:0] K_Q14   = 16'd9949;
  localparam logic [ROW_W-1:0] ROW_MAX = 10'd479;
  localparam logic [ROW_W-1:0] NO_PLOT = 10'd1023;

  // atan(2^-i) in phase units where 2^16 is a full turn
  function automatic logic [15:0] atan_rom(input logic [ITER_IDX_W-1:0] idx);
    logic [15:0] v;
    case (idx)
      5'd0:    v = 16'd8192;
      5'd1:    v = 16'd4836;
      5'd2:    v = 16'd2555;
      5'd3:    v = 16'd1297;
      5'd4:    v = 16'd651;
      5'd5:    v = 16'd326;
      5'd6:    v = 16'd163;
      5'd7:    v = 16'd81;
      5'd8:    v = 16'd41;
      5'd9:    v = 16'd20;
      5'd10:   v = 16'd10;
      5'd11:   v = 16'd5;
      5'd12:   v = 16'd3;
      5'd13:   v = 16'd1;
      5'd14:   v = 16'd1;
      default: v = 16'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_rotator.sv
// Iterative CORDIC rotation-mode datapath: one micro-rotation per step,
// leaving sin(z_init) in Q1.14 on y_out after the last step.
module cordic_rotator
  import cordic_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         load,
  input  logic                         step,
  input  logic signed [DP_W-1:0]       z_init,
  input  logic [ITER_IDX_W-1:0]        iter,
  output logic signed [DP_W-1:0]       y_out
);

  logic signed [DP_W-1:0] x_q, y_q, z_q;
  logic signed [DP_W-1:0] x_sh, y_sh, atan_c;

  always_comb begin
    x_sh   = x_q >>> iter;
    y_sh   = y_q >>> iter;
    atan_c = DP_W'(atan_rom(iter));
  end

  // Rotate toward zero residual angle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
    end else if (load) begin
      x_q <= DP_W'(K_Q14);
      y_q <= '0;
      z_q <= z_init;
    end else if (step) begin
      if (!z_q[DP_W-1]) begin
        x_q <= x_q - y_sh;
        y_q <= y_q + x_sh;
        z_q <= z_q - atan_c;
      end else begin
        x_q <= x_q + y_sh;
        y_q <= y_q - x_sh;
        z_q <= z_q + atan_c;
      end
    end
  end

  assign y_out = y_q;

endmodule

// File: rtl/cordic_sine_gen.sv
// Builds an NCOLS-entry table of sine-wave row positions on each vs falling edge
// and serves it to the renderer. Define CORDIC_PHASE_SCROLL_EN to scroll the wave.
module cordic_sine_gen
  import cordic_pkg::*;
#(
  parameter int NCOLS     = 640,
  parameter int ITER      = 14,
  parameter int PHASE_INC = 102,
  parameter int AMP       = 200,
  parameter int CENTER    = 240
) (
  input  logic             mclk,
  input  logic             start_n,
  input  logic             vs,
  input  logic [9:0]       rd_col,
  output logic [9:0]       rd_y,
  output logic             busy,
  output logic             frame_done
);

  state_t state, state_next;

  logic                    vs_q;
  logic                    trig_c;
  logic                    done_c;
  logic [ITER_IDX_W-1:0]   iter_q;
  logic [ROW_W-1:0]        col_q;
  logic [PHASE_W-1:0]      phase_q;
  logic [PHASE_W-1:0]      phase_base;
  logic                    neg_q;
  logic [ROW_W-1:0]        row_q;
  logic                    table_valid;

  logic signed [DP_W-1:0]   z_fold_c;
  logic signed [DP_W-1:0]   y_r;
  logic [FRAC_W:0]          mag_c;
  logic signed [Q14_W-1:0]  sin_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [PROD_W-1:0] row_w;
  logic [ROW_W-1:0]         row_c;
  logic                     rd_in_range;

  logic [ROW_W-1:0] lbuf [NCOLS];

  assign trig_c = vs_q & ~vs;

  always_ff @(posedge mclk or negedge start_n) begin
    if (!start_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    done_c     = 1'b0;
    case (state)
      S_IDLE:   if (trig_c) state_next = S_LOAD;
      S_LOAD:   state_next = S_ROTATE;
      S_ROTATE: if (iter_q == ITER_IDX_W'(ITER - 1)) state_next = S_SCALE;
      S_SCALE:  state_next = S_WRITE;
      S_WRITE: begin
        if (col_q < ROW_W'(NCOLS - 1)) begin
          state_next = S_LOAD;
        end else begin
          state_next = S_IDLE;
          done_c     = 1'b1;
        end
      end
      default:  state_next = S_IDLE;
    endcase
  end

  // Fold the phase into [0, pi/2]; quadrants 2-3 negate the result
  always_comb begin
    if (phase_q[14]) z_fold_c = DP_W'(ONE_Q14) - DP_W'(phase_q[13:0]);
    else             z_fold_c = DP_W'(phase_q[13:0]);
  end

  cordic_rotator u_rot (
    .clk    (mclk),
    .rst_n  (start_n),
    .load   (state == S_LOAD),
    .step   (state == S_ROTATE),
    .z_init (z_fold_c),
    .iter   (iter_q),
    .y_out  (y_r)
  );

  // Folded angle is non-negative, so clip CORDIC residue to [0, 1.0] before signing
  always_comb begin
    if (y_r[DP_W-1])                  mag_c = '0;
    else if (y_r > DP_W'(ONE_Q14))    mag_c = (FRAC_W+1)'(ONE_Q14);
    else                              mag_c = y_r[FRAC_W:0];
    sin_c  = neg_q ? -$signed(Q14_W'(mag_c)) : $signed(Q14_W'(mag_c));
    prod_c = PROD_W'(sin_c) * PROD_W'(AMP);
    row_w  = PROD_W'(CENTER) - (prod_c >>> FRAC_W);
    if (row_w < 0)                         row_c = '0;
    else if (row_w > PROD_W'(ROW_MAX))     row_c = ROW_MAX;
    else                                   row_c = row_w[ROW_W-1:0];
  end

  always_ff @(posedge mclk or negedge start_n) begin
    if (!start_n) begin
      vs_q        <= 1'b1;
      iter_q      <= '0;
      col_q       <= '0;
      phase_q     <= '0;
      neg_q       <= 1'b0;
      row_q       <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      table_valid <= 1'b0;
    end else begin
      vs_q       <= vs;
      busy       <= (state_next != S_IDLE);
      frame_done <= done_c;
      if (done_c) table_valid <= 1'b1;
      case (state)
        S_IDLE: begin
          if (trig_c) begin
            col_q   <= '0;
            phase_q <= phase_base;
          end
        end
        S_LOAD: begin
          iter_q <= '0;
          neg_q  <= phase_q[15];
        end
        S_ROTATE: iter_q <= iter_q + 1'b1;
        S_SCALE:  row_q  <= row_c;
        S_WRITE: begin
          col_q   <= col_q + 1'b1;
          phase_q <= phase_q + PHASE_W'(PHASE_INC);
        end
        default: ;
      endcase
    end
  end

`ifdef CORDIC_PHASE_SCROLL_EN
  always_ff @(posedge mclk or negedge start_n) begin
    if (!start_n)    phase_base <= '0;
    else if (done_c) phase_base <= phase_base + PHASE_W'(SCROLL_STEP);
  end
`else
  assign phase_base = '0;
`endif

  // Line buffer survives reset so the renderer never sees it scrubbed
  always_ff @(posedge mclk) begin
    if (state == S_WRITE) lbuf[col_q] <= row_q;
  end

  assign rd_in_range = ({1'b0, rd_col} < 11'(NCOLS));

  always_ff @(posedge mclk or negedge start_n) begin
    if (!start_n)                         rd_y <= NO_PLOT;
    else if (!table_valid || !rd_in_range) rd_y <= NO_PLOT;
    else                                  rd_y <= lbuf[rd_col];
  end

endmodule

// File: tb/tb_cordic_sine_gen.sv
// Self-checking bench for cordic_sine_gen: build timing, table contents against a
// floating-point sine model, out-of-range reads, ignored retrigger and mid-build reset.
module tb_cordic_sine_gen;

  localparam int NCOLS     = 640;
  localparam int ITER      = 14;
  localparam int PHASE_INC = 102;
  localparam int AMP       = 200;
  localparam int CENTER    = 240;
  localparam int BUILD     = NCOLS * (ITER + 3);
  localparam int BUDGET    = BUILD + 200;
  localparam real PI       = 3.14159265358979323846;
`ifdef CORDIC_PHASE_SCROLL_EN
  localparam int SCROLL = 256;
`else
  localparam int SCROLL = 0;
`endif

  logic       mclk = 1'b0;
  logic       start_n;
  logic       vs;
  logic [9:0] rd_col;
  logic [9:0] rd_y;
  logic       busy;
  logic       frame_done;

  int total = 0;
  int bad   = 0;
  int model_base = 0;
  int last_base  = 0;
  int done_at, done_cnt, busy_low_at;

  typedef struct {
    int col;
    int exp;
    int tol;
  } vec_t;
  vec_t tbl[8];

  cordic_sine_gen #(
    .NCOLS(NCOLS), .ITER(ITER), .PHASE_INC(PHASE_INC), .AMP(AMP), .CENTER(CENTER)
  ) dut (
    .mclk       (mclk),
    .start_n    (start_n),
    .vs         (vs),
    .rd_col     (rd_col),
    .rd_y       (rd_y),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 mclk = ~mclk;

  // Ideal sine row for a column, straight from phase arithmetic
  function automatic int model_row(input int col, input int base);
    int  ph, v, r;
    real s;
    if (col >= NCOLS) return 1023;
    ph = (base + col * PHASE_INC) % 65536;
    s  = $sin(2.0 * PI * real'(ph) / 65536.0);
    v  = int'($floor(s * real'(AMP)));
    r  = CENTER - v;
    if (r < 0)   r = 0;
    if (r > 479) r = 479;
    return r;
  endfunction

  task automatic chk(input string name, input int got, input int exp, input int tol);
    total++;
    if (got - exp > tol || exp - got > tol) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (tol %0d)", name, got, exp, tol);
    end
  endtask

  task automatic read_col(input int col, output int y);
    rd_col = 10'(col);
    @(negedge mclk);
    y = int'(rd_y);
  endtask

  task automatic trigger();
    @(negedge mclk);
    vs = 1'b0;
    @(negedge mclk);
    chk("busy_one_cycle_after_vs", int'(busy), 1, 0);
    vs = 1'b1;
  endtask

  // Runs a fixed window after the trigger, recording frame_done and busy behaviour
  task automatic wait_done(input int vs2_at, input bit check_blank,
                           output int d_at, output int d_cnt, output int b_low);
    d_at = -1; d_cnt = 0; b_low = -1;
    for (int n = 1; n <= BUDGET; n++) begin
      if (n == vs2_at)     vs = 1'b0;
      if (n == vs2_at + 3) vs = 1'b1;
      @(negedge mclk);
      if (frame_done) begin
        d_cnt++;
        if (d_at < 0) d_at = n;
      end
      if (!busy && b_low < 0) b_low = n;
      if (check_blank && n == 100) chk("rd_y_blank_before_first_done", int'(rd_y), 1023, 0);
    end
  endtask

  task automatic check_build(input string tag);
    chk({tag, "_done_cycle"}, done_at, BUILD, 0);
    chk({tag, "_done_count"}, done_cnt, 1, 0);
    chk({tag, "_busy_fall"}, busy_low_at, BUILD, 0);
  endtask

  task automatic random_reads(input string tag, input int n);
    int c, y;
    for (int i = 0; i < n; i++) begin
      c = int'($urandom_range(767, 0));
      read_col(c, y);
      chk({tag, "_rand_col"}, y, model_row(c, last_base), (c >= NCOLS) ? 0 : 1);
    end
  endtask

  initial begin
    int y, bb;
    tbl[0] = '{col: 0,    exp: 240,  tol: 0};
    tbl[1] = '{col: 160,  exp: 40,   tol: 1};
    tbl[2] = '{col: 480,  exp: 440,  tol: 1};
    tbl[3] = '{col: 320,  exp: 238,  tol: 1};
    tbl[4] = '{col: 639,  exp: 247,  tol: 1};
    tbl[5] = '{col: 700,  exp: 1023, tol: 0};
    tbl[6] = '{col: 640,  exp: 1023, tol: 0};
    tbl[7] = '{col: 1023, exp: 1023, tol: 0};

    start_n = 1'b0;
    vs      = 1'b1;
    rd_col  = 10'd0;
    repeat (3) @(negedge mclk);
    chk("reset_busy", int'(busy), 0, 0);
    chk("reset_frame_done", int'(frame_done), 0, 0);
    chk("reset_rd_y", int'(rd_y), 1023, 0);
    start_n = 1'b1;
    @(negedge mclk);
    chk("post_reset_rd_y", int'(rd_y), 1023, 0);

    // First build from reset
    bb = model_base;
    trigger();
    wait_done(0, 1'b1, done_at, done_cnt, busy_low_at);
    check_build("build1");
    last_base  = bb;
    model_base = (model_base + SCROLL) % 65536;

    for (int i = 0; i < 8; i++) begin
      read_col(tbl[i].col, y);
      chk($sformatf("table_col%0d", tbl[i].col), y, tbl[i].exp, tbl[i].tol);
    end
    random_reads("build1", 40);

    // Retrigger mid-build must be ignored
    bb = model_base;
    rd_col = 10'd0;
    trigger();
    wait_done(5000, 1'b0, done_at, done_cnt, busy_low_at);
    check_build("retrigger");
    last_base  = bb;
    model_base = (model_base + SCROLL) % 65536;
    read_col(0, y);
    chk("build2_col0", y, (SCROLL != 0) ? 235 : 240, 1);
    random_reads("build2", 20);

    // Reset in the middle of a build
    rd_col = 10'd0;
    trigger();
    repeat (3000) @(negedge mclk);
    start_n = 1'b0;
    @(negedge mclk);
    chk("midreset_busy", int'(busy), 0, 0);
    chk("midreset_frame_done", int'(frame_done), 0, 0);
    chk("midreset_rd_y", int'(rd_y), 1023, 0);
    start_n = 1'b1;
    model_base = 0;
    @(negedge mclk);
    bb = model_base;
    trigger();
    wait_done(0, 1'b1, done_at, done_cnt, busy_low_at);
    check_build("rebuild");
    last_base  = bb;
    model_base = (model_base + SCROLL) % 65536;
    read_col(0, y);
    chk("rebuild_col0", y, 240, 0);
    random_reads("rebuild", 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
